ws2812b_chain: RTL and testbench



---
 rtl/ws2812b_chain_if.sv | 25 ++
 rtl/ws2812b_chain.sv | 225 ++++++++++++++++++++++
 tb/tb_ws2812b_chain.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_chain_if.sv
// Peripheral bus bundle for the WS2812B chain driver: byte address, 32-bit data, strobes.
// read_data is driven combinationally by the slave from address.
interface ws2812b_chain_if;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        we;
    logic        re;

    modport master (
        output address,
        output write_data,
        output we,
        output re,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  we,
        input  re,
        output read_data
    );
endinterface

// File: rtl/ws2812b_chain.sv
// WS2812B chain driver: memory-mapped GRB pixel buffer shifted out MSB-first as timed pulses on ws_out.
// Single-cycle bus writes, combinational reads; `define WS2812B_BRIGHTNESS_EN adds CTRL[15:8] brightness scaling.
module ws2812b_chain #(
    parameter int NUM_LEDS    = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int T0H_NS      = 400,
    parameter int T0L_NS      = 850,
    parameter int T1H_NS      = 800,
    parameter int T1L_NS      = 450,
    parameter int TRESET_NS   = 50_000
) (
    input  logic           clk,
    input  logic           rst,
    ws2812b_chain_if.slave bus,
    output logic           ws_out
);
    localparam longint NS_PER_S = 64'd1_000_000_000;
    localparam longint CLK_L    = longint'(CLK_FREQ_HZ);
    localparam int T0H_CYC  = int'((longint'(T0H_NS)    * CLK_L + NS_PER_S - 64'd1) / NS_PER_S);
    localparam int T0L_CYC  = int'((longint'(T0L_NS)    * CLK_L + NS_PER_S - 64'd1) / NS_PER_S);
    localparam int T1H_CYC  = int'((longint'(T1H_NS)    * CLK_L + NS_PER_S - 64'd1) / NS_PER_S);
    localparam int T1L_CYC  = int'((longint'(T1L_NS)    * CLK_L + NS_PER_S - 64'd1) / NS_PER_S);
    localparam int TRST_CYC = int'((longint'(TRESET_NS) * CLK_L + NS_PER_S - 64'd1) / NS_PER_S);
    localparam int TMAX_A   = (T0H_CYC > T0L_CYC) ? T0H_CYC : T0L_CYC;
    localparam int TMAX_B   = (T1H_CYC > T1L_CYC) ? T1H_CYC : T1L_CYC;
    localparam int TMAX_C   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMAX     = (TMAX_C > TRST_CYC) ? TMAX_C : TRST_CYC;
    localparam int CW       = $clog2(TMAX + 1);
    localparam int IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] T0H_LD  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T0L_LD  = CW'(T0L_CYC - 1);
    localparam logic [CW-1:0] T1H_LD  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] T1L_LD  = CW'(T1L_CYC - 1);
    localparam logic [CW-1:0] TRST_LD = CW'(TRST_CYC - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

    logic [23:0]   pix_q [NUM_LEDS];
    logic          cont_q;
    logic [5:0]    len_q;
    logic [7:0]    bright_rd;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] led_idx_q, led_idx_d;
    logic [23:0]   sr_q, sr_d;
    logic [5:0]    act_len_q, act_len_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          ws_out_q;

    logic          pix_hit, ctrl_hit, stat_hit, len_hit, start_wr, busy, last_led;
    logic [IW-1:0] pix_idx;
    logic [5:0]    len_wr;
    logic [23:0]   pix_raw, pix_load;
    logic [31:0]   rdata;
    logic          unused_bus;

    assign pix_hit  = (bus.address[7] == 1'b0) && (bus.address[1:0] == 2'b00)
                   && ({27'd0, bus.address[6:2]} < 32'(NUM_LEDS));
    assign ctrl_hit = (bus.address == 8'h80);
    assign stat_hit = (bus.address == 8'h84);
    assign len_hit  = (bus.address == 8'h88);
    assign pix_idx  = bus.address[IW+1:2];
    assign start_wr = bus.we && ctrl_hit && bus.write_data[0];
    assign busy     = (state_q != ST_IDLE);
    assign last_led = (({{(6-IW){1'b0}}, led_idx_q} + 6'd1) == act_len_q);
    assign pix_raw  = pix_q[led_idx_q];
    assign unused_bus = ^{bus.re, bus.write_data[31:24]};

`ifdef WS2812B_BRIGHTNESS_EN
    logic [7:0] bright_q;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

    assign pix_load  = {scale8(pix_raw[23:16], bright_q),
                        scale8(pix_raw[15:8],  bright_q),
                        scale8(pix_raw[7:0],   bright_q)};
    assign bright_rd = bright_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= 8'hFF;
        end else if (bus.we && ctrl_hit) begin
            bright_q <= bus.write_data[15:8];
        end
    end
`else
    assign pix_load  = pix_raw;
    assign bright_rd = 8'h00;
`endif

    always_comb begin
        len_wr = bus.write_data[5:0];
        if (bus.write_data[5:0] == 6'd0) begin
            len_wr = 6'd1;
        end else if ({26'd0, bus.write_data[5:0]} > 32'(NUM_LEDS)) begin
            len_wr = 6'(NUM_LEDS);
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (pix_hit) begin
            rdata = {8'h00, pix_q[pix_idx]};
        end else if (ctrl_hit) begin
            rdata = {16'h0000, bright_rd, 6'd0, cont_q, 1'b0};
        end else if (stat_hit) begin
            rdata = {frame_cnt_q, 15'd0, busy};
        end else if (len_hit) begin
            rdata = {26'd0, len_q};
        end
    end
    assign bus.read_data = rdata;

    // The current bit always sits in sr_q[23]; LOW shifts the next one up as it returns to HIGH.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        led_idx_d   = led_idx_q;
        sr_d        = sr_q;
        act_len_d   = act_len_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_wr || cont_q) begin
                    state_d   = ST_LOAD;
                    act_len_d = len_q;
                    led_idx_d = '0;
                end
            end
            ST_LOAD: begin
                sr_d      = pix_load;
                bit_idx_d = 5'd23;
                cnt_d     = pix_load[23] ? T1H_LD : T0H_LD;
                state_d   = ST_HIGH;
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d   = sr_q[23] ? T1L_LD : T0L_LD;
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (bit_idx_q != 5'd0) begin
                    bit_idx_d = bit_idx_q - 5'd1;
                    sr_d      = {sr_q[22:0], 1'b0};
                    cnt_d     = sr_q[22] ? T1H_LD : T0H_LD;
                    state_d   = ST_HIGH;
                end else if (last_led) begin
                    cnt_d   = TRST_LD;
                    state_d = ST_LATCH;
                end else begin
                    led_idx_d = led_idx_q + IW'(1);
                    state_d   = ST_LOAD;
                end
            end
            ST_LATCH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (cont_q) begin
                        state_d   = ST_LOAD;
                        act_len_d = len_q;
                        led_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pix_q[i] <= 24'd0;
            end
            cont_q      <= 1'b0;
            len_q       <= 6'(NUM_LEDS);
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 5'd0;
            led_idx_q   <= '0;
            sr_q        <= 24'd0;
            act_len_q   <= 6'(NUM_LEDS);
            frame_cnt_q <= 16'd0;
            ws_out_q    <= 1'b0;
        end else begin
            if (bus.we && pix_hit) begin
                pix_q[pix_idx] <= bus.write_data[23:0];
            end
            if (bus.we && ctrl_hit) begin
                cont_q <= bus.write_data[1];
            end
            if (bus.we && len_hit) begin
                len_q <= len_wr;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            led_idx_q   <= led_idx_d;
            sr_q        <= sr_d;
            act_len_q   <= act_len_d;
            frame_cnt_q <= frame_cnt_d;
            ws_out_q    <= (state_d == ST_HIGH);
        end
    end

    assign ws_out = ws_out_q;
endmodule

// File: tb/tb_ws2812b_chain.sv
// Bench for ws2812b_chain: register vector table plus a pulse-width scoreboard on ws_out.
`timescale 1ns/1ps
module tb_ws2812b_chain;
    localparam int NUM_LEDS = 8;
    localparam int T0H = 20, T0L = 43, T1H = 40, T1L = 23, TRST = 2500;
    localparam logic [31:0] CB = 32'h0000FF00;
`ifdef WS2812B_BRIGHTNESS_EN
    localparam logic [31:0] CTRL_RST = 32'h0000FF00;
    localparam logic [31:0] CTRL_AA  = 32'h0000AA00;
    localparam logic [31:0] CTRL_7F  = 32'h00007F00;
    localparam logic [23:0] TX_BR    = 24'h7F4020;
`else
    localparam logic [31:0] CTRL_RST = 32'h0;
    localparam logic [31:0] CTRL_AA  = 32'h0;
    localparam logic [31:0] CTRL_7F  = 32'h0;
    localparam logic [23:0] TX_BR    = 24'hFF8040;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ws_out;
    ws2812b_chain_if bus();

    ws2812b_chain #(.NUM_LEDS(NUM_LEDS), .CLK_FREQ_HZ(50_000_000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ws_out(ws_out)
    );

    always #10 clk = ~clk;

    typedef struct { int hi; int lo; bit lo_idle; } bit_exp_t;
    typedef struct { bit wr; logic [7:0] addr; logic [31:0] wd; logic [31:0] exp; string nm; } vec_t;

    bit_exp_t    sb_q[$];
    vec_t        vq[$];
    logic [23:0] tx_m [NUM_LEDS];
    int n_vec = 0, n_bad = 0, cyc = 0;
    int extra_pulses = 0, last_fall_cyc = 0, idle_lo_exp = -1, run = 0;
    bit mon_en = 1'b0, have_pend = 1'b0;
    logic prev_lvl = 1'b0;
    bit_exp_t pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: each falling edge pops one expected bit; low time is checked at the next rise.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_lvl = 1'b0; run = 0; have_pend = 1'b0;
        end else if (ws_out !== prev_lvl) begin
            if (prev_lvl === 1'b1) begin
                last_fall_cyc = cyc;
                if (sb_q.size() == 0) begin
                    extra_pulses++;
                    have_pend = 1'b0;
                end else begin
                    pend = sb_q.pop_front();
                    have_pend = 1'b1;
                    chk("bit_high", run, pend.hi);
                    idle_lo_exp = pend.lo_idle ? pend.lo : -1;
                end
            end else begin
                if (have_pend && !pend.lo_idle) chk("bit_low", run, pend.lo);
                have_pend = 1'b0;
            end
            prev_lvl = ws_out;
            run = 1;
        end else begin
            run++;
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus.address = a; bus.write_data = d; bus.we = 1'b1;
        @(posedge clk); #1;
        bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        bus.address = a; bus.re = 1'b1;
        #1 d = bus.read_data;
        bus.re = 1'b0;
    endtask

    task automatic addv(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.wd = d; v.exp = e; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic push_frame(input int len, input bit more);
        for (int l = 0; l < len; l++) begin
            for (int b = 23; b >= 0; b--) begin
                bit_exp_t e;
                logic [23:0] p;
                p = tx_m[l];
                e.hi = p[b] ? T1H : T0H;
                e.lo = p[b] ? T1L : T0L;
                e.lo_idle = 1'b0;
                if (b == 0 && l < len - 1) e.lo += 1;
                else if (b == 0 && more) e.lo += TRST + 1;
                else if (b == 0) begin
                    e.lo += TRST;
                    e.lo_idle = 1'b1;
                end
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int exp_fc);
        logic [31:0] st;
        int n;
        n = 0;
        bus.address = 8'h84;
        #1 st = bus.read_data;
        while (st[0] && n < 40000) begin
            @(posedge clk); #1;
            st = bus.read_data;
            n++;
        end
        chk({nm, "_busy"}, {31'd0, st[0]}, 32'd0);
        chk({nm, "_latch_len"}, cyc - last_fall_cyc, idle_lo_exp);
        chk({nm, "_frame_cnt"}, {16'd0, st[31:16]}, exp_fc);
        chk({nm, "_drain"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int n, hi_seen;
        bus.address = 8'h00; bus.write_data = 32'h0; bus.we = 1'b0; bus.re = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        addv(0, 8'h84, 0, 32'h0, "rst_status");
        addv(0, 8'h88, 0, 32'd8, "rst_len");
        addv(0, 8'h80, 0, CTRL_RST, "rst_ctrl");
        addv(0, 8'h00, 0, 32'h0, "rst_pix0");
        addv(1, 8'h88, 32'd0, 0, "");
        addv(0, 8'h88, 0, 32'd1, "len_zero_clamp");
        addv(1, 8'h88, 32'd40, 0, "");
        addv(0, 8'h88, 0, 32'd8, "len_big_clamp");
        addv(1, 8'h88, 32'd3, 0, "");
        addv(0, 8'h88, 0, 32'd3, "len_mid");
        addv(1, 8'h20, 32'h00123456, 0, "");
        addv(0, 8'h20, 0, 32'h0, "pix_out_of_range");
        addv(1, 8'h1C, 32'hAABBCCDD, 0, "");
        addv(0, 8'h1C, 0, 32'h00BBCCDD, "pix7_upper_masked");
        addv(1, 8'h04, 32'h00C0FFEE, 0, "");
        addv(0, 8'h04, 0, 32'h00C0FFEE, "pix1_readback");
        addv(0, 8'h8C, 0, 32'h0, "unmapped_8c");
        addv(0, 8'h40, 0, 32'h0, "unmapped_40");
        addv(1, 8'h80, 32'h0000AA00, 0, "");
        addv(0, 8'h80, 0, CTRL_AA, "ctrl_bright_field");
        addv(1, 8'h80, CB, 0, "");
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].wr) bus_wr(vq[i].addr, vq[i].wd);
            else begin
                bus_rd(vq[i].addr, rd);
                chk(vq[i].nm, rd, vq[i].exp);
            end
        end

        // One-shot single LED frame.
        bus_wr(8'h00, 32'h00800001); tx_m[0] = 24'h800001;
        bus_wr(8'h88, 32'd1);
        push_frame(1, 1'b0);
        bus_wr(8'h80, CB | 32'h1);
        wait_idle("one_shot", 1);

        // START while busy, pixel writes mid-frame, LEN write while busy.
        bus_wr(8'h88, 32'd2);
        bus_wr(8'h00, 32'h0000FF00); tx_m[0] = 24'h00FF00;
        bus_wr(8'h04, 32'h000F0F0F); tx_m[1] = 24'h5A5A5A;
        push_frame(2, 1'b0);
        bus_wr(8'h80, CB | 32'h1);
        repeat (200) @(posedge clk);
        #1;
        bus_wr(8'h80, CB | 32'h1);
        bus_wr(8'h04, 32'h005A5A5A);
        bus_wr(8'h00, 32'h00123456);
        bus_wr(8'h88, 32'd1);
        wait_idle("busy_start", 2);
        bus_rd(8'h88, rd);
        chk("len_busy_write", rd, 32'd1);
        tx_m[0] = 24'h123456;
        push_frame(1, 1'b0);
        bus_wr(8'h80, CB | 32'h1);
        wait_idle("len_next_frame", 3);

        // Continuous refresh, CONT cleared during the third frame.
        bus_wr(8'h88, 32'd2);
        push_frame(2, 1'b1);
        push_frame(2, 1'b1);
        push_frame(2, 1'b0);
        bus_wr(8'h80, CB | 32'h3);
        n = 0;
        bus.address = 8'h84;
        #1;
        while (bus.read_data[31:16] != 16'd5 && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cont_two_frames", {16'd0, bus.read_data[31:16]}, 32'd5);
        repeat (300) @(posedge clk);
        #1;
        bus_wr(8'h80, CB);
        wait_idle("cont_stop", 6);
        repeat (3000) @(posedge clk);
        #1;
        chk("cont_no_restart", sb_q.size(), 32'd0);
        bus_rd(8'h84, rd);
        chk("cont_status_final", rd, 32'h00060000);

        // Reset in the middle of a high phase.
        mon_en = 1'b0;
        sb_q.delete();
        bus_wr(8'h00, 32'h00FFFFFF);
        bus_wr(8'h88, 32'd1);
        bus_wr(8'h80, CB | 32'h3);
        n = 0;
        while (ws_out !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_saw_high", {31'd0, ws_out}, 32'd1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ws_out_low", {31'd0, ws_out}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        hi_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (ws_out !== 1'b0) hi_seen++;
        end
        chk("rst_no_edges", hi_seen, 32'd0);
        bus_rd(8'h00, rd); chk("rst2_pix0", rd, 32'h0);
        bus_rd(8'h88, rd); chk("rst2_len", rd, 32'd8);
        bus_rd(8'h80, rd); chk("rst2_ctrl", rd, CTRL_RST);
        bus_rd(8'h84, rd); chk("rst2_status", rd, 32'h0);
        mon_en = 1'b1;

        // Brightness scaling (identity when the feature is not built).
        bus_wr(8'h80, 32'h00007F00);
        bus_wr(8'h00, 32'h00FF8040); tx_m[0] = TX_BR;
        bus_wr(8'h88, 32'd1);
        push_frame(1, 1'b0);
        bus_wr(8'h80, 32'h00007F01);
        wait_idle("bright", 1);
        bus_rd(8'h00, rd); chk("bright_readback", rd, 32'h00FF8040);
        bus_rd(8'h80, rd); chk("bright_ctrl", rd, CTRL_7F);

        chk("extra_pulses", extra_pulses, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
